spi_accel_responder: RTL and testbench



---
 rtl/spi_accel_responder.sv | 146 ++++++++++++++
 tb/tb_spi_accel_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_accel_responder.sv
// spi_accel_responder: SPI mode-0 responder emulating the ADXL362 register map.
// Ports: i_clk/i_rst system clock and async active-high reset; i_sclk/i_cs_n/i_mosi/o_miso
// SPI lines (oversampled in i_clk); i_sample_valid/i_x/i_y/i_z sample feed; o_power_ctl reg 0x2D.
// Optional: define SPI_RESP_SOFT_RESET_EN to enable soft reset by writing 0x52 to 0x1F.
module spi_accel_responder #(
  parameter logic [7:0] DEVID_AD  = 8'hAD,
  parameter logic [7:0] DEVID_MST = 8'h1D,
  parameter logic [7:0] PARTID    = 8'hF2,
  parameter logic [7:0] REVID     = 8'h01
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sclk,
  input  logic        i_cs_n,
  input  logic        i_mosi,
  output logic        o_miso,
  input  logic        i_sample_valid,
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  input  logic [11:0] i_z,
  output logic [7:0]  o_power_ctl
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;
  state_t r_state, w_state_n;
  logic [2:0] r_sclk, r_cs, r_mosi;
  logic [2:0] r_bit;
  logic [6:0] r_rx;
  logic [7:0] r_tx, w_byte, w_rd_data;
  logic [5:0] r_addr, w_rd_addr;
  logic r_rd, r_miso, r_ready, r_hit;
  logic [11:0] r_x, r_y, r_z, r_sx, r_sy, r_sz;
  logic [7:0] r_mem [32];
  logic w_rise, w_fall, w_cs_fall, w_cs_rise, w_shift, w_done, w_soft;
  // [1] is the synchronized level, [2] the history used for edge detection
  assign w_rise    = r_sclk[1] & ~r_sclk[2] & ~r_cs[1];
  assign w_fall    = ~r_sclk[1] & r_sclk[2] & ~r_cs[1];
  assign w_cs_fall = ~r_cs[1] & r_cs[2];
  assign w_cs_rise = r_cs[1] & ~r_cs[2];
  assign w_shift   = w_rise && (r_state inside {CMD, ADDR, DATA});
  assign w_done    = w_shift && r_bit == 3'd7;
  // MOSI is taken from the older copy, which was stable a full cycle before the detected rise
  assign w_byte    = {r_rx, r_mosi[2]};
  // address of the byte to prefetch: the received address, or the next one in a burst
  assign w_rd_addr = r_state == ADDR ? w_byte[5:0] : r_addr + 6'd1;
  assign o_miso      = r_miso;
  assign o_power_ctl = r_mem[13];
`ifdef SPI_RESP_SOFT_RESET_EN
  logic r_soft;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_soft <= 1'b0;
    else if (w_cs_rise) r_soft <= 1'b0;
    else if (w_done && r_state == DATA && !r_rd && r_addr == 6'h1F && w_byte == 8'h52) r_soft <= 1'b1;
  assign w_soft = r_soft & w_cs_rise;
`else
  assign w_soft = 1'b0;
`endif
  always_comb begin
    w_rd_data = 8'h00;
    case (w_rd_addr)
      6'h00: w_rd_data = DEVID_AD;
      6'h01: w_rd_data = DEVID_MST;
      6'h02: w_rd_data = PARTID;
      6'h03: w_rd_data = REVID;
      6'h08: w_rd_data = r_sx[11:4];
      6'h09: w_rd_data = r_sy[11:4];
      6'h0A: w_rd_data = r_sz[11:4];
      6'h0B: w_rd_data = {7'd0, r_ready};
      6'h0E: w_rd_data = r_sx[7:0];
      6'h0F: w_rd_data = {{4{r_sx[11]}}, r_sx[11:8]};
      6'h10: w_rd_data = r_sy[7:0];
      6'h11: w_rd_data = {{4{r_sy[11]}}, r_sy[11:8]};
      6'h12: w_rd_data = r_sz[7:0];
      6'h13: w_rd_data = {{4{r_sz[11]}}, r_sz[11:8]};
      default: w_rd_data = w_rd_addr[5] ? r_mem[w_rd_addr[4:0]] : 8'h00;
    endcase
  end
  always_comb begin
    w_state_n = r_state;
    if (w_cs_rise) w_state_n = IDLE;
    else if (r_state == IDLE) w_state_n = w_cs_fall ? CMD : IDLE;
    else if (w_done) w_state_n = r_state != CMD ? DATA : (w_byte == 8'h0B || w_byte == 8'h0A) ? ADDR : IGNORE;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= IDLE;
    else r_state <= w_state_n;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_sclk  <= 3'b000;
      r_cs    <= 3'b111;
      r_mosi  <= 3'b000;
      r_bit   <= 3'd0;
      r_rx    <= 7'd0;
      r_tx    <= 8'd0;
      r_addr  <= 6'd0;
      r_rd    <= 1'b0;
      r_miso  <= 1'b0;
      r_hit   <= 1'b0;
      r_ready <= 1'b0;
      r_x     <= 12'd0;
      r_y     <= 12'd0;
      r_z     <= 12'd0;
      r_sx    <= 12'd0;
      r_sy    <= 12'd0;
      r_sz    <= 12'd0;
      r_mem   <= '{default: 8'd0};
    end else begin
      r_sclk <= {r_sclk[1:0], i_sclk};
      r_cs   <= {r_cs[1:0], i_cs_n};
      r_mosi <= {r_mosi[1:0], i_mosi};
      if (w_cs_fall) begin
        r_bit <= 3'd0;
        r_hit <= 1'b0;
        r_sx  <= r_x;
        r_sy  <= r_y;
        r_sz  <= r_z;
      end else if (w_shift) begin
        r_bit <= r_bit + 3'd1;
        r_rx  <= w_byte[6:0];
      end
      if (w_done && r_state == CMD) r_rd <= w_byte == 8'h0B;
      if (w_done && r_state != CMD) r_addr <= w_rd_addr;
      if (w_done && r_state != CMD) r_tx <= w_rd_data;
      else if (w_fall && r_state == DATA && r_rd) r_tx <= {r_tx[6:0], 1'b0};
      if (w_done && r_state == DATA && !r_rd && r_addr[5]) r_mem[r_addr[4:0]] <= w_byte;
      if (w_done && r_state == DATA && r_rd && r_addr inside {[6'h08:6'h13]}) r_hit <= 1'b1;
      r_miso <= (r_state == DATA && r_rd && !w_cs_rise) ? (w_fall ? r_tx[7] : r_miso) : 1'b0;
      if (w_cs_rise && r_hit) r_ready <= 1'b0;
      if (w_soft) begin
        r_mem   <= '{default: 8'd0};
        r_ready <= 1'b0;
        r_x     <= 12'd0;
        r_y     <= 12'd0;
        r_z     <= 12'd0;
        r_sx    <= 12'd0;
        r_sy    <= 12'd0;
        r_sz    <= 12'd0;
      end
      // a new sample takes priority over any clear in the same cycle
      if (i_sample_valid) begin
        r_x     <= i_x;
        r_y     <= i_y;
        r_z     <= i_z;
        r_ready <= 1'b1;
      end
    end
endmodule

// File: tb/tb_spi_accel_responder.sv
// tb_spi_accel_responder: directed and randomized SPI transactions checked against a register-map model.
module tb_spi_accel_responder;
  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, sv = 1'b0;
  logic [11:0] x = 12'd0, y = 12'd0, z = 12'd0;
  logic miso;
  logic [7:0] pctl;
  int checks = 0, failures = 0;
  logic [7:0] m_mem [64];
  logic [11:0] m_live [3];
  logic [11:0] snap [3];
  logic m_ready = 1'b0, m_soft = 1'b0;
  logic [7:0] ids [4] = '{8'hAD, 8'h1D, 8'hF2, 8'h01};

  always #5 clk = ~clk;

  spi_accel_responder dut (
    .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi), .o_miso(miso),
    .i_sample_valid(sv), .i_x(x), .i_y(y), .i_z(z), .o_power_ctl(pctl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] m_rd(input int a);
    logic [11:0] v;
    if (a < 4) return ids[a];
    if (a >= 8 && a <= 10) begin
      v = snap[a - 8];
      return v[11:4];
    end
    if (a == 11) return {7'd0, m_ready};
    if (a >= 14 && a <= 19) begin
      v = snap[(a - 14) / 2];
      return (a % 2 == 0) ? v[7:0] : 8'($signed(v) >>> 8);
    end
    if (a >= 32) return m_mem[a];
    return 8'h00;
  endfunction

  task automatic model_clear();
    foreach (m_mem[i]) m_mem[i] = 8'h00;
    foreach (m_live[i]) begin
      m_live[i] = 12'd0;
      snap[i] = 12'd0;
    end
    m_ready = 1'b0;
    m_soft = 1'b0;
  endtask

  task automatic model_cs_rise(input bit hit);
    if (hit) m_ready = 1'b0;
    if (m_soft) model_clear();
  endtask

  task automatic xfer(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nb; i++) begin
      mosi = tx[7 - i];
      wait_clk(8);
      rx = {rx[6:0], miso};
      sclk = 1'b1;
      wait_clk(8);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    foreach (m_live[i]) snap[i] = m_live[i];
    wait_clk(8);
  endtask

  task automatic cs_end();
    wait_clk(8);
    cs_n = 1'b1;
    wait_clk(10);
  endtask

  task automatic spi_read(input logic [7:0] addr, input int n, input string tag);
    logic [7:0] rx;
    int a;
    bit hit;
    hit = 1'b0;
    cs_begin();
    xfer(8'h0B, 8, rx);
    chk({tag, " miso-in-cmd"}, rx, 8'h00);
    xfer(addr, 8, rx);
    chk({tag, " miso-in-addr"}, rx, 8'h00);
    for (int i = 0; i < n; i++) begin
      a = (int'(addr) + i) % 64;
      xfer(8'h00, 8, rx);
      chk($sformatf("%s byte%0d@%02h", tag, i, a), rx, m_rd(a));
      if (a >= 8 && a <= 19) hit = 1'b1;
    end
    cs_end();
    model_cs_rise(hit);
  endtask

  task automatic spi_write(input logic [7:0] addr, input int n, input logic [23:0] d);
    logic [7:0] rx, b;
    int a;
    cs_begin();
    xfer(8'h0A, 8, rx);
    xfer(addr, 8, rx);
    for (int i = 0; i < n; i++) begin
      a = (int'(addr) + i) % 64;
      b = d[23 - 8 * i -: 8];
      xfer(b, 8, rx);
      if (a >= 32) m_mem[a] = b;
`ifdef SPI_RESP_SOFT_RESET_EN
      if (a == 31 && b == 8'h52) m_soft = 1'b1;
`endif
      chk($sformatf("power_ctl after write@%02h", a), pctl, m_mem[45]);
    end
    cs_end();
    model_cs_rise(1'b0);
  endtask

  task automatic pulse(input logic [11:0] px, input logic [11:0] py, input logic [11:0] pz);
    @(negedge clk);
    sv = 1'b1;
    x = px;
    y = py;
    z = pz;
    @(negedge clk);
    sv = 1'b0;
    m_live[0] = px;
    m_live[1] = py;
    m_live[2] = pz;
    m_ready = 1'b1;
  endtask

  initial begin
    logic [7:0] rx;
    model_clear();
    wait_clk(3);
    chk("reset miso", miso, 1'b0);
    chk("reset power_ctl", pctl, 8'h00);
    rst = 1'b0;
    wait_clk(5);
    spi_read(8'h00, 4, "id");
    spi_write(8'h2D, 1, 24'h020000);
    spi_read(8'h2D, 1, "power_ctl rb");
    pulse(12'hF85, 12'h123, 12'h7FF);
    spi_read(8'h0B, 5, "status/x");
    spi_read(8'h0B, 1, "status cleared");
    spi_read(8'h08, 3, "axis hi");
    spi_read(8'h10, 4, "y/z lo-hi");
    spi_write(8'h3E, 3, 24'hAABBCC);
    spi_read(8'h3E, 2, "burst rb");
    spi_read(8'h20, 1, "0x20 unchanged");
    spi_read(8'h00, 1, "0x00 unchanged");
    // unknown command: everything after it must be ignored
    cs_begin();
    xfer(8'h55, 8, rx);
    xfer(8'h0A, 8, rx);
    chk("ignore miso1", rx, 8'h00);
    xfer(8'h2D, 8, rx);
    chk("ignore miso2", rx, 8'h00);
    xfer(8'hFF, 8, rx);
    chk("ignore miso3", rx, 8'h00);
    cs_end();
    chk("ignore power_ctl", pctl, m_mem[45]);
    // aborted write after 5 data bits
    cs_begin();
    xfer(8'h0A, 8, rx);
    xfer(8'h25, 8, rx);
    xfer(8'hFF, 5, rx);
    cs_end();
    spi_read(8'h25, 1, "aborted write");
    // sample arriving mid-transaction must not tear the snapshot
    pulse(12'h5A3, 12'h0F0, 12'h801);
    cs_begin();
    xfer(8'h0B, 8, rx);
    xfer(8'h0E, 8, rx);
    pulse(12'h111, 12'h222, 12'h333);
    xfer(8'h00, 8, rx);
    chk("snapshot xl", rx, m_rd(14));
    xfer(8'h00, 8, rx);
    chk("snapshot xh", rx, m_rd(15));
    cs_end();
    model_cs_rise(1'b1);
    spi_read(8'h0B, 1, "status after torn-read test");
    spi_read(8'h0E, 6, "new sample");
    // soft reset sequence (no effect without the macro)
    spi_write(8'h20, 1, 24'h110000);
    pulse(12'h7FF, 12'h800, 12'h001);
    spi_write(8'h1F, 1, 24'h520000);
    spi_read(8'h20, 1, "after soft-reset 0x20");
    spi_read(8'h0B, 1, "after soft-reset status");
    spi_read(8'h1F, 1, "0x1F reads 0");
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 2))
        0: spi_write(8'(8'h20 + $urandom_range(0, 31)), int'($urandom_range(1, 3)), 24'($urandom));
        1: spi_read(8'($urandom), int'($urandom_range(1, 4)), "rand-rd");
        default: pulse(12'($urandom), 12'($urandom), 12'($urandom));
      endcase
    end
    // reset in the middle of a write clears storage and samples
    spi_write(8'h2D, 1, 24'h5C0000);
    pulse(12'h321, 12'h654, 12'h987);
    cs_begin();
    xfer(8'h0A, 8, rx);
    xfer(8'h30, 8, rx);
    xfer(8'hA5, 3, rx);
    rst = 1'b1;
    wait_clk(2);
    chk("midreset miso", miso, 1'b0);
    chk("midreset power_ctl", pctl, 8'h00);
    cs_n = 1'b1;
    sclk = 1'b0;
    wait_clk(2);
    rst = 1'b0;
    model_clear();
    wait_clk(10);
    spi_read(8'h00, 64, "full map after reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
